// File: rtl/and4_sweep_ctrl.sv
// Clocked stimulus sequencer and checker for a 4-input AND cell.
// Each vector is held for a latched hold time, and gate mismatches are counted.
//
// state | meaning
// IDLE  | gate inputs parked at 4'hF, waiting for start
// RUN   | driving vector step_idx, hold window counting down
// DONE  | one-cycle completion pulse, then back to IDLE
module and4_sweep_ctrl #(
  parameter int HOLD_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              dut_out,
  output logic [3:0]        drv,
  output logic              busy,
  output logic              done,
  output logic [4:0]        step_idx,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [4:0]        first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t            state;
  logic              mode_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_m1;
  logic [4:0]        last_step;
  logic              exp_out;

  // Walking-zero places the zero in odd steps only; even steps park at F.
  function automatic logic [3:0] vec_of(input logic m, input logic [4:0] k);
    logic [3:0] v;
    v = 4'hF;
    if (m)
      v = k[3:0];
    else if (k[0])
      v = ~(4'b0001 << k[2:1]);
    return v;
  endfunction

  // Reload value of the hold down-counter; a zero hold time behaves as one.
  assign hold_m1   = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;
  assign last_step = mode_q ? 5'd15 : 5'd8;
  assign exp_out   = &vec_of(mode_q, step_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      hold_q        <= '0;
      hold_cnt      <= '0;
      drv           <= 4'hF;
      busy          <= 1'b0;
      done          <= 1'b0;
      step_idx      <= '0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          drv  <= 4'hF;
          busy <= 1'b0;
          if (start) begin
            state         <= RUN;
            mode_q        <= mode;
            hold_q        <= hold_m1;
            hold_cnt      <= hold_m1;
            step_idx      <= '0;
            drv           <= vec_of(mode, 5'd0);
            busy          <= 1'b1;
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
            drv   <= 4'hF;
            busy  <= 1'b0;
          end else if (hold_cnt == '0) begin
            if (dut_out != exp_out) begin
              if (err_cnt != ERR_MAX)
                err_cnt <= err_cnt + 1'b1;
              if (err_cnt == '0)
                first_err_idx <= step_idx;
              err_flag <= 1'b1;
            end
            if (step_idx == last_step) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              drv   <= 4'hF;
            end else begin
              step_idx <= step_idx + 5'd1;
              drv      <= vec_of(mode_q, step_idx + 5'd1);
              hold_cnt <= hold_q;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          drv   <= 4'hF;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          drv   <= 4'hF;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
